// File: rtl/bin_rtc_pkg.sv
// bin_rtc_pkg: shared constants, set-target encoding and 12 h display helper
// for the binary real-time clock.
package bin_rtc_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;

  // Maps an internal 0-23 hour to {pm, 1-12 display hour}.
  function automatic logic [5:0] to_12h(input logic [4:0] h);
    logic       pm;
    logic [4:0] m;
    pm = (h >= 5'd12);
    m  = pm ? (h - 5'd12) : h;
    return {pm, (m == 5'd0) ? 5'd12 : m};
  endfunction

endpackage

// File: rtl/bin_rtc_wrap_ctr.sv
// bin_rtc_wrap_ctr: mod-(MAX+1) up/down counter.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset (count -> 0)
//   inc_i    step up, MAX wraps to 0 (wins if inc_i and dec_i coincide)
//   dec_i    step down, 0 wraps to MAX
//   count_o  current value
//   carry_o  high when this cycle's increment wraps MAX -> 0
module bin_rtc_wrap_ctr #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         carry_o
);

  localparam logic [W-1:0] TOP = W'(MAX);

  assign carry_o = inc_i && (count_o == TOP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= (count_o == TOP) ? '0 : count_o + W'(1);
    end else if (dec_i) begin
      count_o <= (count_o == '0) ? TOP : count_o - W'(1);
    end
  end

endmodule

// File: rtl/bin_rtc.sv
// bin_rtc: binary real-time clock with 12/24 h display, set stepping and an
// hh:mm alarm.
//   CLK_HZ        input clock frequency in Hz (>= 2)
//   clk_i         system clock
//   reset_i       asynchronous active-high reset
//   time_set_i    1 = set mode (counting frozen), 0 = run
//   id_switch_i   step direction: 1 = increment, 0 = decrement
//   hour_id_i     hour step request (rising edge)
//   minute_id_i   minute step request (rising edge)
//   seconds_id_i  seconds step request (rising edge)
//   target_sel_i  set-mode target: 0 = time, 1 = alarm
//   mode_24h_i    1 = 24 h display, 0 = 12 h display
//   alarm_en_i    alarm enable
//   hour_o, minute_o, seconds_o, pm_o   displayed time (or alarm while editing it)
//   tick_o        one-cycle pulse per elapsed second
//   alarm_o       one-cycle alarm-match pulse
module bin_rtc #(
  parameter int CLK_HZ = 100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       time_set_i,
  input  logic       id_switch_i,
  input  logic       hour_id_i,
  input  logic       minute_id_i,
  input  logic       seconds_id_i,
  input  logic       target_sel_i,
  input  logic       mode_24h_i,
  input  logic       alarm_en_i,
  output logic [4:0] hour_o,
  output logic [5:0] minute_o,
  output logic [5:0] seconds_o,
  output logic       pm_o,
  output logic       tick_o,
  output logic       alarm_o
);
  import bin_rtc_pkg::*;

  localparam int             PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tick_en;
  logic          hour_prev, min_prev, sec_prev;
  logic          hour_edge, min_edge, sec_edge;
  logic          sec_step, min_step, hour_step;
  logic          to_alarm;
  target_e       tgt;

  logic       sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic       amin_inc, amin_dec, ahour_inc, ahour_dec;
  logic       sec_carry, min_carry, hour_carry;
  logic       amin_carry_unused, ahour_carry_unused;
  logic [5:0] sec, min, amin;
  logic [4:0] hour, ahour;
  logic [5:0] next_min;
  logic [4:0] next_hour;
  logic       alarm_hit;

  assign tick_en = !time_set_i && (presc == PRE_LAST);

  // Prescaler is parked at 0 in set mode so leaving set mode starts a full second.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc <= '0;
    end else if (time_set_i || tick_en) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hour_prev <= 1'b0;
      min_prev  <= 1'b0;
      sec_prev  <= 1'b0;
    end else begin
      hour_prev <= hour_id_i;
      min_prev  <= minute_id_i;
      sec_prev  <= seconds_id_i;
    end
  end

  assign hour_edge = hour_id_i && !hour_prev;
  assign min_edge  = minute_id_i && !min_prev;
  assign sec_edge  = seconds_id_i && !sec_prev;

  // One step per cycle; a seconds edge consumes the cycle even when it is
  // ignored for the alarm target.
  assign sec_step  = time_set_i && sec_edge;
  assign min_step  = time_set_i && !sec_edge && min_edge;
  assign hour_step = time_set_i && !sec_edge && !min_edge && hour_edge;

  assign tgt      = target_e'(target_sel_i);
  assign to_alarm = (tgt == TGT_ALARM);

  // Run-mode carries chain combinationally so a full rollover lands on one edge.
  assign sec_inc  = tick_en || (sec_step && !to_alarm && id_switch_i);
  assign sec_dec  = sec_step && !to_alarm && !id_switch_i;
  assign min_inc  = (tick_en && sec_carry) || (min_step && !to_alarm && id_switch_i);
  assign min_dec  = min_step && !to_alarm && !id_switch_i;
  assign hour_inc = (tick_en && min_carry) || (hour_step && !to_alarm && id_switch_i);
  assign hour_dec = hour_step && !to_alarm && !id_switch_i;

  assign amin_inc  = min_step && to_alarm && id_switch_i;
  assign amin_dec  = min_step && to_alarm && !id_switch_i;
  assign ahour_inc = hour_step && to_alarm && id_switch_i;
  assign ahour_dec = hour_step && to_alarm && !id_switch_i;

  bin_rtc_wrap_ctr #(.MAX(SEC_MAX), .W(6)) u_sec (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(sec_inc), .dec_i(sec_dec),
    .count_o(sec), .carry_o(sec_carry)
  );

  bin_rtc_wrap_ctr #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(min_inc), .dec_i(min_dec),
    .count_o(min), .carry_o(min_carry)
  );

  bin_rtc_wrap_ctr #(.MAX(HOUR_MAX), .W(5)) u_hour (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(hour_inc), .dec_i(hour_dec),
    .count_o(hour), .carry_o(hour_carry)
  );

  bin_rtc_wrap_ctr #(.MAX(MIN_MAX), .W(6)) u_amin (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(amin_inc), .dec_i(amin_dec),
    .count_o(amin), .carry_o(amin_carry_unused)
  );

  bin_rtc_wrap_ctr #(.MAX(HOUR_MAX), .W(5)) u_ahour (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(ahour_inc), .dec_i(ahour_dec),
    .count_o(ahour), .carry_o(ahour_carry_unused)
  );

  // Time as it will be after this tick, so the registered alarm pulse lines
  // up with the new hh:mm:00 appearing on the outputs.
  assign next_min  = min_carry  ? 6'd0 : min  + {5'd0, min_inc};
  assign next_hour = hour_carry ? 5'd0 : hour + {4'd0, hour_inc};
  assign alarm_hit = tick_en && sec_carry && alarm_en_i &&
                     (next_min == amin) && (next_hour == ahour);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_o  <= 1'b0;
      alarm_o <= 1'b0;
    end else begin
      tick_o  <= tick_en;
      alarm_o <= alarm_hit;
    end
  end

  logic       show_alarm;
  logic [4:0] disp_h;
  logic [5:0] h12;

  assign show_alarm = time_set_i && to_alarm;
  assign disp_h     = show_alarm ? ahour : hour;
  assign h12        = to_12h(disp_h);

  always_comb begin
    minute_o  = show_alarm ? amin : min;
    seconds_o = show_alarm ? 6'd0 : sec;
    if (mode_24h_i) begin
      hour_o = disp_h;
      pm_o   = 1'b0;
    end else begin
      hour_o = h12[4:0];
      pm_o   = h12[5];
    end
  end

endmodule

// File: tb/tb_bin_rtc.sv
module tb_bin_rtc;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       time_set_i, id_switch_i, hour_id_i, minute_id_i, seconds_id_i;
  logic       target_sel_i, mode_24h_i, alarm_en_i;
  logic [4:0] hour_o;
  logic [5:0] minute_o, seconds_o;
  logic       pm_o, tick_o, alarm_o;

  int n_cmp = 0;
  int n_bad = 0;

  bin_rtc #(.CLK_HZ(10)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .time_set_i(time_set_i),
    .id_switch_i(id_switch_i), .hour_id_i(hour_id_i), .minute_id_i(minute_id_i),
    .seconds_id_i(seconds_id_i), .target_sel_i(target_sel_i),
    .mode_24h_i(mode_24h_i), .alarm_en_i(alarm_en_i), .hour_o(hour_o),
    .minute_o(minute_o), .seconds_o(seconds_o), .pm_o(pm_o), .tick_o(tick_o),
    .alarm_o(alarm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // which = {hour, minute, seconds}; each step is one rising request then release.
  task automatic step(input logic [2:0] which, input int n);
    repeat (n) begin
      hour_id_i    = which[2];
      minute_id_i  = which[1];
      seconds_id_i = which[0];
      edges(1);
      hour_id_i    = 1'b0;
      minute_id_i  = 1'b0;
      seconds_id_i = 1'b0;
      edges(1);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(hour_o), 32'(h));
    chk({tag, ".min"},  32'(minute_o), 32'(m));
    chk({tag, ".sec"},  32'(seconds_o), 32'(s));
  endtask

  initial begin
    reset_i = 1'b1; time_set_i = 0; id_switch_i = 0; hour_id_i = 0;
    minute_id_i = 0; seconds_id_i = 0; target_sel_i = 0; mode_24h_i = 1;
    alarm_en_i = 0;
    #12;
    chk_time("rst", 0, 0, 0);
    chk("rst.tick", 32'(tick_o), 0);
    chk("rst.alarm", 32'(alarm_o), 0);
    chk("rst.pm", 32'(pm_o), 0);
    mode_24h_i = 0; #1;
    chk("rst12.hour", 32'(hour_o), 12);
    chk("rst12.pm", 32'(pm_o), 0);
    mode_24h_i = 1;
    reset_i = 0;

    // first second on the 10th edge, first minute on the 600th
    edges(9);
    chk("e9.sec", 32'(seconds_o), 0);
    chk("e9.tick", 32'(tick_o), 0);
    edges(1);
    chk("e10.sec", 32'(seconds_o), 1);
    chk("e10.tick", 32'(tick_o), 1);
    edges(1);
    chk("e11.tick", 32'(tick_o), 0);
    edges(588);
    chk_time("e599", 0, 0, 59);
    edges(1);
    chk_time("e600", 0, 1, 0);
    chk("e600.tick", 32'(tick_o), 1);

    // coincident seconds+minute edges: seconds only
    time_set_i = 1; id_switch_i = 1;
    step(3'b011, 1);
    chk_time("coinc", 0, 1, 1);

    // build 23:59:59 with decrements; hour 0 -> 23
    id_switch_i = 0;
    step(3'b001, 1);
    step(3'b010, 2);
    step(3'b001, 1);
    step(3'b100, 1);
    chk_time("set235959", 23, 59, 59);
    mode_24h_i = 0; #1;
    chk("dec12.hour", 32'(hour_o), 11);
    chk("dec12.pm", 32'(pm_o), 1);
    mode_24h_i = 1;

    // held request gives exactly one step
    id_switch_i = 1; hour_id_i = 1;
    edges(20);
    hour_id_i = 0;
    edges(1);
    chk("hold.hour", 32'(hour_o), 0);
    chk("set.tick", 32'(tick_o), 0);
    id_switch_i = 0;
    step(3'b100, 1);
    chk("redec.hour", 32'(hour_o), 23);

    // leaving set mode restarts the second; full rollover on one edge
    time_set_i = 0;
    edges(9);
    chk_time("pre_roll", 23, 59, 59);
    chk("pre_roll.tick", 32'(tick_o), 0);
    edges(1);
    chk_time("roll", 0, 0, 0);
    chk("roll.tick", 32'(tick_o), 1);
    mode_24h_i = 0; #1;
    chk("roll12.hour", 32'(hour_o), 12);
    chk("roll12.pm", 32'(pm_o), 0);

    // 11:59:59 -> 12 PM in 12 h mode
    time_set_i = 1; id_switch_i = 1;
    step(3'b100, 11);
    id_switch_i = 0;
    step(3'b010, 1);
    step(3'b001, 1);
    chk_time("set115959", 11, 59, 59);
    chk("set115959.pm", 32'(pm_o), 0);
    time_set_i = 0;
    edges(10);
    chk_time("noon", 12, 0, 0);
    chk("noon.pm", 32'(pm_o), 1);

    // alarm 07:30
    time_set_i = 1; target_sel_i = 1; id_switch_i = 1;
    step(3'b100, 7);
    step(3'b010, 30);
    chk_time("alm_view", 7, 30, 0);
    chk("alm_view.pm", 32'(pm_o), 0);
    id_switch_i = 0;
    step(3'b011, 1);
    chk("alm_secign.min", 32'(minute_o), 30);
    target_sel_i = 0; #1;
    chk_time("time_view", 12, 0, 0);
    chk("time_view.pm", 32'(pm_o), 1);
    mode_24h_i = 1;
    step(3'b100, 5);
    step(3'b010, 31);
    step(3'b001, 1);
    chk_time("set072959", 7, 29, 59);
    chk("set.alarm", 32'(alarm_o), 0);
    alarm_en_i = 1; time_set_i = 0;
    edges(9);
    chk("pre_alm.alarm", 32'(alarm_o), 0);
    edges(1);
    chk("alm.alarm", 32'(alarm_o), 1);
    chk("alm.tick", 32'(tick_o), 1);
    chk_time("alm", 7, 30, 0);
    edges(1);
    chk("post_alm.alarm", 32'(alarm_o), 0);

    // same crossing with alarm disabled
    time_set_i = 1; alarm_en_i = 0;
    step(3'b010, 1);
    step(3'b001, 1);
    time_set_i = 0;
    edges(10);
    chk("noalm.alarm", 32'(alarm_o), 0);
    chk("noalm.tick", 32'(tick_o), 1);
    chk_time("noalm", 7, 30, 0);

    // asynchronous reset mid-second at 12:34:56
    time_set_i = 1; id_switch_i = 1;
    step(3'b100, 5);
    step(3'b010, 4);
    id_switch_i = 0;
    step(3'b001, 4);
    time_set_i = 0;
    edges(5);
    chk_time("pre_rst", 12, 34, 56);
    #2 reset_i = 1;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst.tick", 32'(tick_o), 0);
    chk("arst.alarm", 32'(alarm_o), 0);
    chk("arst.pm", 32'(pm_o), 0);
    mode_24h_i = 0; #1;
    chk("arst12.hour", 32'(hour_o), 12);
    mode_24h_i = 1;
    reset_i = 0;
    edges(9);
    chk("rel9.tick", 32'(tick_o), 0);
    chk("rel9.sec", 32'(seconds_o), 0);
    edges(1);
    chk("rel10.tick", 32'(tick_o), 1);
    chk("rel10.sec", 32'(seconds_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
